hot_vector_buffer: RTL
======================

Name: hot_vector_buffer

Overview:
- Parametrised successor to the PuDianNao hot buffer.
- Stores DEPTH entries of LANES x DATA_W words. Each entry is one complete MLU input vector.
- Adds independent write and read ports, valid/ready handshakes, and burst reads with address wrap-around.
- Adds per-entry valid tracking, a single-cycle clear, and write-first collision forwarding.
- Sits between the DMA/load unit (writer) and the MLU input stage (reader).

Parameters:
- DATA_W, 32, bits per lane word
- LANES, 16, words per entry (MLU input dimension)
- DEPTH, 256, number of entries; must be a power of two, at least 2
- IDX_W, $clog2(DEPTH), index width (derived; do not override)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- clr  in  1  single-cycle pulse; invalidates all entries
- wr_valid  in  1  write request
- wr_ready  out  1  write accepted when high; tied high (writes never stall)
- wr_idx  in  IDX_W  write entry index
- wr_data  in  LANES x DATA_W  write vector
- cmd_valid  in  1  burst-read command request
- cmd_ready  out  1  high only in IDLE
- cmd_base  in  IDX_W  first entry of the burst
- cmd_len  in  IDX_W  beats minus 1 (0 = 1 beat, DEPTH-1 = DEPTH beats)
- rd_valid  out  1  read beat valid
- rd_ready  in  1  consumer accepts the beat
- rd_data  out  LANES x DATA_W  read vector
- rd_last  out  1  final beat of the burst
- rd_miss  out  1  entry was not written since the last reset/clr; rd_data is forced to 0
- busy  out  1  FSM in BURST, or rd_valid high

Behaviour:
- Reset (async, rst=1):
  - FSM goes to IDLE; rd_valid, rd_last, rd_miss and busy go to 0; rd_data goes to 0.
  - All valid bits are cleared. RAM contents are not reset.
  - Reset mid-burst abandons the burst; no further beats are issued.
- Write:
  - Fires on wr_valid. RAM[wr_idx] <= wr_data and valid[wr_idx] <= 1 at the clock edge.
  - Writes proceed in any FSM state.
- Clear:
  - clr sets all valid bits to 0 at the edge.
  - If clr and a write occur in the same cycle, the written index ends valid=1.
- Advance enable: adv = !rd_valid || rd_ready.
- FSM states are IDLE and BURST.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid && adv: read cmd_base this cycle; rd_valid=1 next cycle (1-cycle latency).
  - If cmd_len==0, that beat carries rd_last=1 and the FSM stays in IDLE. Otherwise load addr=cmd_base+1 and remain=cmd_len-1, then go to BURST.
  - cmd_valid with adv=0 is not accepted (cmd_ready=0 in that case).
- BURST:
  - cmd_ready=0.
  - Each cycle with adv=1: issue a read of addr, then addr <= addr+1 mod DEPTH (wraps DEPTH-1 -> 0), and remain decrements.
  - The read issued when remain==0 carries rd_last=1, and the FSM returns to IDLE.
  - Result: back-to-back beats, one per cycle, with no bubbles when rd_ready is held high.
- Backpressure:
  - While rd_valid && !rd_ready, rd_data, rd_last and rd_miss hold stable.
  - No read is issued and addr/remain are frozen.
- Beat retirement:
  - A beat retires on rd_valid && rd_ready.
  - If no new read is issued in that cycle, rd_valid drops to 0 next cycle.
- Collision:
  - A write and a read issue to the same index in the same cycle returns wr_data with rd_miss=0 (write-first).
  - Write-then-read on consecutive cycles naturally returns the new data.
- Miss:
  - rd_miss = !valid[idx] sampled at read issue, after applying same-cycle write forwarding and clr.
  - When rd_miss=1, rd_data is all zeros.
- A clr during a burst affects only beats issued after the clr edge.
- busy = (state==BURST) || rd_valid.

Decomposition:
- Shared package pudiannao_pkg holds:
  - DATA_W_DEF=32, LANES_DEF=16
  - typedef lane_vec_t (unpacked LANES x DATA_W)
  - enum hvb_state_t {HVB_IDLE, HVB_BURST}
- Sub-module hot_buffer_bank:
  - 1-write/1-read synchronous RAM, DEPTH x (LANES*DATA_W).
  - Read enable and registered output.
  - Write-first bypass on address match.
  - Instantiated once.
- The top level holds the FSM, address/remain counters, the valid-bit vector and the miss/zero logic.

Test Plan:
1. Reset, write idx 5 = lanes {0..15}, then cmd base=5 len=0 with rd_ready=1 -> rd_valid one cycle after acceptance, rd_data {0..15}, rd_last=1, rd_miss=0.
2. Write idx 254, 255, 0, 1 with distinct patterns; cmd base=254 len=3 -> 4 consecutive beats with wrapped order 254, 255, 0, 1; rd_last only on 4th; busy falls the cycle after the last handshake.
3. Burst base=0 len=7 with rd_ready toggled 1,0,0,1,... -> data held stable during stalls, no beat lost or duplicated, exactly 8 handshakes.
4. Read idx 9 never written -> rd_miss=1, rd_data=0. Then write idx 9 in the same cycle as its read issue -> wr_data returned, rd_miss=0.
5. Pulse clr, then read previously written idx 5 -> rd_miss=1. Assert clr together with a write to idx 3 -> idx 3 reads valid.
6. Assert rst mid-burst (base=0, len=15, after 4 beats) -> rd_valid=0 immediately, cmd_ready=1 after deassertion, all entries read rd_miss=1.

Source files
------------

// File: rtl/pudiannao_pkg.sv
// Shared types and defaults for the PuDianNao-derived buffer blocks.
// Holds the lane-vector type and the hot vector buffer FSM encoding.
package pudiannao_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int LANES_DEF  = 16;

  typedef logic [DATA_W_DEF-1:0] lane_vec_t [LANES_DEF];

  typedef enum logic {
    HVB_IDLE  = 1'b0,
    HVB_BURST = 1'b1
  } hvb_state_t;

endpackage

// File: rtl/hot_buffer_bank.sv
// 1-write/1-read synchronous RAM with a registered read port.
// A read and a write to the same address in one cycle return the write data.
module hot_buffer_bank #(
  parameter int DATA_W = 32,
  parameter int LANES  = 16,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          we,
  input  logic [IDX_W-1:0]              waddr,
  input  logic [LANES-1:0][DATA_W-1:0]  wdata,
  input  logic                          re,
  input  logic [IDX_W-1:0]              raddr,
  output logic [LANES-1:0][DATA_W-1:0]  rdata
);

  logic [LANES-1:0][DATA_W-1:0] r_mem [DEPTH];
  logic [LANES-1:0][DATA_W-1:0] r_q;

  // Array contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (re) begin
      r_q <= (we && (waddr == raddr)) ? wdata : r_mem[raddr];
    end
  end

  assign rdata = r_q;

endmodule

// File: rtl/hot_vector_buffer.sv
// Hot vector buffer: DEPTH entries of LANES x DATA_W words, independent write
// port and a burst read port with wrap-around, per-entry valid bits and clear.
module hot_vector_buffer
  import pudiannao_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LANES  = LANES_DEF,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [IDX_W-1:0]              wr_idx,
  input  logic [LANES-1:0][DATA_W-1:0]  wr_data,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [IDX_W-1:0]              cmd_base,
  input  logic [IDX_W-1:0]              cmd_len,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [LANES-1:0][DATA_W-1:0]  rd_data,
  output logic                          rd_last,
  output logic                          rd_miss,
  output logic                          busy
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // Once rd_valid is raised, rd_data/rd_last/rd_miss hold until rd_ready.
  hvb_state_t r_state, w_state_nxt;

  logic [IDX_W-1:0]             r_addr;
  logic [IDX_W-1:0]             r_remain;
  logic [DEPTH-1:0]             r_valid;
  logic [DEPTH-1:0]             w_valid_nxt;
  logic                         r_rd_valid;
  logic                         r_rd_last;
  logic                         r_rd_miss;
  logic                         w_adv;
  logic                         w_issue;
  logic                         w_last;
  logic                         w_hit;
  logic                         w_miss;
  logic [IDX_W-1:0]             w_rd_idx;
  logic [LANES-1:0][DATA_W-1:0] w_bank_q;

  assign wr_ready = 1'b1;
  assign w_adv    = !r_rd_valid || rd_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_last      = 1'b0;
    w_rd_idx    = r_addr;
    cmd_ready   = 1'b0;
    case (r_state)
      HVB_IDLE: begin
        cmd_ready = w_adv;
        w_rd_idx  = cmd_base;
        w_last    = (cmd_len == '0);
        w_issue   = cmd_valid && w_adv;
        if (w_issue && !w_last) begin
          w_state_nxt = HVB_BURST;
        end
      end
      HVB_BURST: begin
        w_last  = (r_remain == '0);
        w_issue = w_adv;
        if (w_issue && w_last) begin
          w_state_nxt = HVB_IDLE;
        end
      end
      default: w_state_nxt = HVB_IDLE;
    endcase
  end

  // A same-cycle write to the read index wins over both clr and a stale valid bit.
  assign w_hit  = wr_valid && (wr_idx == w_rd_idx);
  assign w_miss = !w_hit && (clr || !r_valid[w_rd_idx]);

  always_comb begin
    w_valid_nxt = clr ? '0 : r_valid;
    if (wr_valid) begin
      w_valid_nxt[wr_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= HVB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr   <= '0;
      r_remain <= '0;
    end else if (w_issue) begin
      if (r_state == HVB_IDLE) begin
        r_addr   <= cmd_base + 1'b1;
        r_remain <= cmd_len - 1'b1;
      end else begin
        r_addr   <= r_addr + 1'b1;
        r_remain <= r_remain - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
    end else begin
      r_valid <= w_valid_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      r_rd_miss  <= 1'b0;
    end else if (w_issue) begin
      r_rd_valid <= 1'b1;
      r_rd_last  <= w_last;
      r_rd_miss  <= w_miss;
    end else if (rd_ready) begin
      r_rd_valid <= 1'b0;
    end
  end

  hot_buffer_bank #(
    .DATA_W (DATA_W),
    .LANES  (LANES),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_bank (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_valid),
    .waddr (wr_idx),
    .wdata (wr_data),
    .re    (w_issue),
    .raddr (w_rd_idx),
    .rdata (w_bank_q)
  );

  assign rd_valid = r_rd_valid;
  assign rd_last  = r_rd_last;
  assign rd_miss  = r_rd_miss;
  assign rd_data  = r_rd_miss ? '0 : w_bank_q;
  assign busy     = (r_state == HVB_BURST) || r_rd_valid;

endmodule
